clock_gate_ctrl: RTL and testbench

Idle-detecting controller that drives the enable of a downstream clock-gating cell for one gated clock domain. It watches the domain's busy flag and incoming work requests, shuts the domain clock after a programmable run of idle cycles, and sequences a wake-up with a settle period before reporting the domain ready. It sits in the always-on `i_clk` domain, in front of the gating cell whose enable it owns.

---
 rtl/clock_gate_ctrl_if.sv | 31 +++
 rtl/clock_gate_ctrl.sv | 121 ++++++++++++
 tb/tb_clock_gate_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_gate_ctrl_if.sv
// Signal bundle between the clock-gate controller and the gated domain / requester.
// The controller takes the slave side; the domain/requester takes the master side.
interface clock_gate_ctrl_if;
   logic        i_busy;
   logic        i_req;
   logic        i_force_on;
   logic        o_clock_en;
   logic        o_ready;
   logic        o_gated;
   logic [15:0] o_gate_cnt;

   modport master (
      output i_busy,
      output i_req,
      output i_force_on,
      input  o_clock_en,
      input  o_ready,
      input  o_gated,
      input  o_gate_cnt
   );

   modport slave (
      input  i_busy,
      input  i_req,
      input  i_force_on,
      output o_clock_en,
      output o_ready,
      output o_gated,
      output o_gate_cnt
   );
endinterface

// File: rtl/clock_gate_ctrl.sv
// Idle-detecting clock-gate enable controller for one gated domain, running in the
// always-on clock; gates after a run of idle cycles and sequences a settled wake-up.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | domain clocked, work present or just resumed; ready
// ST_IDLE  | domain clocked, counting consecutive idle cycles; ready
// ST_GATED | enable low, waiting for i_req or i_force_on
// ST_WAKE  | enable high again, counting settle cycles; not ready
module clock_gate_ctrl #(
   parameter int IDLE_CYCLES = 16,
   parameter int WAKE_CYCLES = 2,
   parameter int CNT_W       = 8
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   clock_gate_ctrl_if.slave   cg
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_IDLE  = 2'd1,
      ST_GATED = 2'd2,
      ST_WAKE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [15:0]      GATE_MAX  = 16'hFFFF;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      gate_cnt_q, gate_cnt_d;
   logic             en_q, ready_q, gated_q;
   logic             en_d, ready_d, gated_d;
   logic             idle_cycle;

   assign idle_cycle = ~cg.i_busy & ~cg.i_req & ~cg.i_force_on;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q    <= ST_RUN;
         cnt_q      <= '0;
         gate_cnt_q <= '0;
         en_q       <= 1'b1;
         ready_q    <= 1'b1;
         gated_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gate_cnt_q <= gate_cnt_d;
         en_q       <= en_d;
         ready_q    <= ready_d;
         gated_q    <= gated_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gate_cnt_d = gate_cnt_q;
      unique case (state_q)
         ST_RUN: begin
            if (idle_cycle) begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         ST_IDLE: begin
            // Activity on the threshold edge wins over gating.
            if (!idle_cycle) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else if (cnt_q == IDLE_LAST) begin
               state_d = ST_GATED;
               cnt_d   = '0;
               if (gate_cnt_q != GATE_MAX) begin
                  gate_cnt_d = gate_cnt_q + 16'd1;
               end
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         ST_GATED: begin
            if (cg.i_req || cg.i_force_on) begin
               state_d = ST_WAKE;
               cnt_d   = '0;
            end
         end
         ST_WAKE: begin
            // Settle period always completes, even if the request goes away.
            if (cnt_q == WAKE_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are flopped from the next state so the gating-cell enable is glitch-free.
   always_comb begin
      en_d    = (state_d != ST_GATED);
      ready_d = (state_d == ST_RUN) || (state_d == ST_IDLE);
      gated_d = (state_d == ST_GATED);
   end

   assign cg.o_clock_en = en_q;
   assign cg.o_ready    = ready_q;
   assign cg.o_gated    = gated_q;
   assign cg.o_gate_cnt = gate_cnt_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Self-checking bench for clock_gate_ctrl: directed vector table, hand-written corner
// sequences and random traffic compared against an idle-streak/wake-countdown model.
module tb_clock_gate_ctrl;

   localparam int IDLE_N = 4;
   localparam int WAKE_N = 2;

   logic clk;
   logic rstn;

   clock_gate_ctrl_if ifc ();

   clock_gate_ctrl #(
      .IDLE_CYCLES (IDLE_N),
      .WAKE_CYCLES (WAKE_N),
      .CNT_W       (8)
   ) dut (
      .i_clk  (clk),
      .i_rstn (rstn),
      .cg     (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: the domain is either gated, waking with some cycles left,
   // or running with a count of consecutive idle cycles seen so far.
   bit m_gated;
   int m_wake_left;
   int m_streak;
   int m_cnt;

   function automatic bit m_en();
      return !m_gated;
   endfunction

   function automatic bit m_ready();
      return !m_gated && (m_wake_left == 0);
   endfunction

   task automatic model_reset();
      m_gated     = 1'b0;
      m_wake_left = 0;
      m_streak    = 0;
      m_cnt       = 0;
   endtask

   task automatic model_step(input bit b, input bit r, input bit f);
      if (m_gated) begin
         if (r || f) begin
            m_gated     = 1'b0;
            m_wake_left = WAKE_N;
         end
      end else if (m_wake_left > 0) begin
         m_wake_left = m_wake_left - 1;
      end else if (!b && !r && !f) begin
         m_streak = m_streak + 1;
         if (m_streak == IDLE_N) begin
            m_gated  = 1'b1;
            m_streak = 0;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
         end
      end else begin
         m_streak = 0;
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".en"},    int'(ifc.o_clock_en), int'(m_en()));
      check({tag, ".ready"}, int'(ifc.o_ready),    int'(m_ready()));
      check({tag, ".gated"}, int'(ifc.o_gated),    int'(m_gated));
      check({tag, ".cnt"},   int'(ifc.o_gate_cnt), m_cnt);
   endtask

   task automatic drive(input bit b, input bit r, input bit f);
      ifc.i_busy     = b;
      ifc.i_req      = r;
      ifc.i_force_on = f;
   endtask

   // One clock: apply inputs, step the model on the edge, sample 1 ns later.
   task automatic cycle(input bit b, input bit r, input bit f, input string tag);
      drive(b, r, f);
      @(posedge clk);
      model_step(b, r, f);
      #1;
      check_model(tag);
   endtask

   typedef struct {
      bit          busy;
      bit          req;
      bit          force_on;
      bit          en;
      bit          ready;
      bit          gated;
      int          cnt;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(bit b, bit r, bit f, bit e, bit rd, bit g, int c);
      vec_t v;
      v.busy = b; v.req = r; v.force_on = f;
      v.en = e; v.ready = rd; v.gated = g; v.cnt = c;
      return v;
   endfunction

   task automatic do_reset();
      drive(0, 0, 0);
      rstn = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #3;
      rstn = 1'b1;
      #1;
   endtask

   bit pend;
   bit was_ready;
   bit rb, rr, rf;

   initial begin
      rstn = 1'b0;
      drive(0, 0, 0);
      model_reset();

      // Reset: outputs held at the run values while reset is asserted and after.
      @(posedge clk);
      #1;
      check("rst_during.en",    int'(ifc.o_clock_en), 1);
      check("rst_during.ready", int'(ifc.o_ready),    1);
      check("rst_during.gated", int'(ifc.o_gated),    0);
      check("rst_during.cnt",   int'(ifc.o_gate_cnt), 0);
      #2;
      rstn = 1'b1;
      #1;
      check("rst_after.en",    int'(ifc.o_clock_en), 1);
      check("rst_after.ready", int'(ifc.o_ready),    1);

      // Directed vectors: inputs before an edge, expected outputs after it.
      vt.push_back(mk(0,0,0, 1,1,0,0));  // idle 1
      vt.push_back(mk(0,0,0, 1,1,0,0));  // idle 2
      vt.push_back(mk(1,0,0, 1,1,0,0));  // busy at idle cycle 3 -> restart
      vt.push_back(mk(0,0,0, 1,1,0,0));
      vt.push_back(mk(0,0,0, 1,1,0,0));
      vt.push_back(mk(0,0,0, 1,1,0,0));
      vt.push_back(mk(0,0,0, 0,0,1,1));  // 4th idle edge -> gated
      vt.push_back(mk(1,0,0, 0,0,1,1));  // busy ignored while gated
      vt.push_back(mk(0,1,0, 1,0,0,1));  // edge k: req -> wake
      vt.push_back(mk(0,1,0, 1,0,0,1));  // k+1
      vt.push_back(mk(0,1,0, 1,1,0,1));  // k+2: ready
      vt.push_back(mk(0,1,0, 1,1,0,1));  // k+3: transfer
      vt.push_back(mk(0,0,0, 1,1,0,1));
      vt.push_back(mk(0,0,0, 1,1,0,1));
      vt.push_back(mk(0,0,0, 1,1,0,1));
      vt.push_back(mk(0,0,0, 0,0,1,2));  // regated
      vt.push_back(mk(0,0,1, 1,0,0,2));  // force wakes like req
      vt.push_back(mk(0,0,0, 1,0,0,2));  // force dropped, wake continues
      vt.push_back(mk(0,0,0, 1,1,0,2));
      vt.push_back(mk(0,0,0, 1,1,0,2));
      vt.push_back(mk(0,0,0, 1,1,0,2));
      vt.push_back(mk(0,0,0, 1,1,0,2));
      vt.push_back(mk(0,1,0, 1,1,0,2));  // req on threshold edge -> no gating
      vt.push_back(mk(0,0,0, 1,1,0,2));
      vt.push_back(mk(0,0,0, 1,1,0,2));
      vt.push_back(mk(0,0,0, 1,1,0,2));
      vt.push_back(mk(0,0,0, 0,0,1,3));
      vt.push_back(mk(0,1,0, 1,0,0,3));  // wake
      vt.push_back(mk(0,0,0, 1,0,0,3));  // req withdrawn
      vt.push_back(mk(0,0,0, 1,1,0,3));  // still reaches run
      vt.push_back(mk(0,0,0, 1,1,0,3));
      vt.push_back(mk(0,0,0, 1,1,0,3));
      vt.push_back(mk(0,0,0, 1,1,0,3));
      vt.push_back(mk(0,0,0, 0,0,1,4));  // idle timer restarted after wake

      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i].busy, vt[i].req, vt[i].force_on);
         @(posedge clk);
         model_step(vt[i].busy, vt[i].req, vt[i].force_on);
         #1;
         check($sformatf("vec%0d.en", i),    int'(ifc.o_clock_en), int'(vt[i].en));
         check($sformatf("vec%0d.ready", i), int'(ifc.o_ready),    int'(vt[i].ready));
         check($sformatf("vec%0d.gated", i), int'(ifc.o_gated),    int'(vt[i].gated));
         check($sformatf("vec%0d.cnt", i),   int'(ifc.o_gate_cnt), vt[i].cnt);
      end

      // Force held through 100 otherwise idle cycles: wakes, never regates.
      for (int i = 0; i < 100; i++) cycle(0, 0, 1, "force_hold");
      check("force_hold.cnt_end", int'(ifc.o_gate_cnt), 4);

      // Asynchronous reset in the middle of a wake.
      do_reset();
      for (int i = 0; i < IDLE_N; i++) cycle(0, 0, 0, "pre_wake");
      cycle(0, 1, 0, "wake_start");
      drive(0, 1, 0);
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check("rst_wake.en",    int'(ifc.o_clock_en), 1);
      check("rst_wake.ready", int'(ifc.o_ready),    1);
      check("rst_wake.gated", int'(ifc.o_gated),    0);
      check("rst_wake.cnt",   int'(ifc.o_gate_cnt), 0);
      model_reset();
      drive(0, 0, 0);
      @(posedge clk);
      #3;
      rstn = 1'b1;
      #1;

      // Saturation: preload the gate counter just below the top.
      force dut.gate_cnt_q = 16'hFFFE;
      #1;
      release dut.gate_cnt_q;
      m_cnt = 16'hFFFE;
      for (int g = 0; g < 3; g++) begin
         for (int i = 0; i < IDLE_N; i++) cycle(0, 0, 0, "sat_idle");
         for (int i = 0; i < WAKE_N + 1; i++) cycle(0, 1, 0, "sat_wake");
      end
      check("sat.final", int'(ifc.o_gate_cnt), 65535);

      // Random traffic with a protocol-correct requester.
      do_reset();
      pend = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!pend && ($urandom_range(0, 11) == 0)) pend = 1'b1;
         rr = pend;
         rb = ($urandom_range(0, 9) == 0);
         rf = ($urandom_range(0, 29) == 0);
         was_ready = m_ready();
         cycle(rb, rr, rf, "rand");
         if (pend && was_ready) pend = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
